// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one memory read per fetch_start, then a one-cycle IRWrite pulse; PC advances or redirects.
// Latency: mem_req 1 cycle after fetch_start, IRWrite 1 cycle after mem_ready; stalls in REQ until ready or timeout.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instrData,
    output logic              IRWrite,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_FAULT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            S_IDLE, S_FAULT: begin
                // A redirect and a start in the same cycle: REQ fetches from the new target.
                if (branch_valid) pc_d = branch_target;
                if (fetch_start) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                // PC must stay put while the read is outstanding, so redirects wait until WRITE.
                if (branch_valid) begin
                    pend_vld_d = 1'b1;
                    pend_tgt_d = branch_target;
                end
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    state_d = S_WRITE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d    = S_FAULT;
                    if (pend_vld_d) pc_d = pend_tgt_d;
                    pend_vld_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: begin
                if (branch_valid)    pc_d = branch_target;
                else if (pend_vld_q) pc_d = pend_tgt_q;
                else                 pc_d = pc_q + ADDR_W'(PC_STEP);
                pend_vld_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign mem_req     = (state_q == S_REQ);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instrData   = instr_q;
    assign IRWrite     = (state_q == S_WRITE);
    assign fetch_done  = (state_q == S_WRITE);
    assign fetch_busy  = (state_q == S_REQ) || (state_q == S_WRITE);
    assign fetch_fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand-written timeout, reset and wrap sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start, branch_valid, mem_ready;
    logic [31:0] branch_target, mem_rdata;
    logic        mem_req, IRWrite, fetch_busy, fetch_done, fetch_fault;
    logic [31:0] mem_addr, instrData, pc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .fetch_start(fetch_start), .branch_valid(branch_valid), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .instrData(instrData), .IRWrite(IRWrite), .pc(pc),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_fault(fetch_fault)
    );

    typedef struct {
        logic        fs, bv;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        irw;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        busy;
        logic        fault;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic fs, logic bv, logic [31:0] tgt, logic rdy, logic [31:0] rdata,
                                logic req, logic [31:0] addr, logic irw, logic [31:0] instr,
                                logic [31:0] epc, logic busy, logic fault);
        vec_t v;
        v.fs = fs; v.bv = bv; v.tgt = tgt; v.rdy = rdy; v.rdata = rdata;
        v.req = req; v.addr = addr; v.irw = irw; v.instr = instr; v.pc = epc;
        v.busy = busy; v.fault = fault;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic bv, input logic [31:0] tgt,
                         input logic rdy, input logic [31:0] rdata);
        fetch_start = fs; branch_valid = bv; branch_target = tgt;
        mem_ready = rdy; mem_rdata = rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  req_cycles, irw_seen;
    bit  got_fault;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step(); step();
        reset = 1'b0;

        //            fs bv tgt           rdy rdata          req addr          irw instr          pc            busy flt
        vecs[0]  = mk(1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,        0, 0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 32'h2008_0005, 1, 32'h0,        0, 32'h0,         32'h0,        1, 0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 32'h2008_0005, 32'h0,        1, 0);
        vecs[3]  = mk(1, 0, 32'h0,        0, 32'h0,         0, 32'h4,        0, 32'h2008_0005, 32'h4,        0, 0);
        vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        0, 32'h2008_0005, 32'h4,        1, 0);
        vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        0, 32'h2008_0005, 32'h4,        1, 0);
        vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        0, 32'h2008_0005, 32'h4,        1, 0);
        vecs[7]  = mk(0, 0, 32'h0,        1, 32'hAAAA_0001, 1, 32'h4,        0, 32'h2008_0005, 32'h4,        1, 0);
        vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,         0, 32'h4,        1, 32'hAAAA_0001, 32'h4,        1, 0);
        vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,         0, 32'h8,        0, 32'hAAAA_0001, 32'h8,        0, 0);
        vecs[10] = mk(0, 1, 32'h100,      0, 32'h0,         1, 32'h8,        0, 32'hAAAA_0001, 32'h8,        1, 0);
        vecs[11] = mk(0, 0, 32'h0,        1, 32'h1111_2222, 1, 32'h8,        0, 32'hAAAA_0001, 32'h8,        1, 0);
        vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 32'h1111_2222, 32'h8,        1, 0);
        vecs[13] = mk(1, 1, 32'h300,      0, 32'h0,         0, 32'h100,      0, 32'h1111_2222, 32'h100,      0, 0);
        vecs[14] = mk(0, 0, 32'h0,        1, 32'h3333_4444, 1, 32'h300,      0, 32'h1111_2222, 32'h300,      1, 0);
        vecs[15] = mk(0, 1, 32'h400,      0, 32'h0,         0, 32'h300,      1, 32'h3333_4444, 32'h300,      1, 0);
        vecs[16] = mk(0, 0, 32'h0,        0, 32'h0,         0, 32'h400,      0, 32'h3333_4444, 32'h400,      0, 0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].fs, vecs[i].bv, vecs[i].tgt, vecs[i].rdy, vecs[i].rdata);
            check($sformatf("v%0d mem_req", i),    {31'b0, mem_req},    {31'b0, vecs[i].req});
            check($sformatf("v%0d mem_addr", i),   mem_addr,            vecs[i].addr);
            check($sformatf("v%0d IRWrite", i),    {31'b0, IRWrite},    {31'b0, vecs[i].irw});
            check($sformatf("v%0d fetch_done", i), {31'b0, fetch_done}, {31'b0, vecs[i].irw});
            check($sformatf("v%0d instrData", i),  instrData,           vecs[i].instr);
            check($sformatf("v%0d pc", i),         pc,                  vecs[i].pc);
            check($sformatf("v%0d fetch_busy", i), {31'b0, fetch_busy}, {31'b0, vecs[i].busy});
            check($sformatf("v%0d fetch_fault", i),{31'b0, fetch_fault},{31'b0, vecs[i].fault});
            step();
        end

        // Timeout: 15 not-ready REQ cycles, then FAULT with pc unchanged.
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        req_cycles = 0; irw_seen = 0; got_fault = 0;
        for (int c = 0; c < 40 && !got_fault; c++) begin
            if (mem_req) req_cycles++;
            if (IRWrite) irw_seen++;
            if (fetch_fault) got_fault = 1;
            else step();
        end
        check("timeout reached", {31'b0, got_fault}, 32'd1);
        check("timeout req cycles", req_cycles, 32'd15);
        check("timeout no IRWrite", irw_seen, 32'd0);
        check("fault mem_req", {31'b0, mem_req}, 32'd0);
        check("fault pc", pc, 32'h400);
        check("fault busy", {31'b0, fetch_busy}, 32'd0);
        drive(1, 0, 0, 0, 0);
        step();
        check("retry fault clear", {31'b0, fetch_fault}, 32'd0);
        check("retry mem_req", {31'b0, mem_req}, 32'd1);
        check("retry addr", mem_addr, 32'h400);
        drive(0, 0, 0, 1, 32'h5555_6666);
        step();
        check("retry IRWrite", {31'b0, IRWrite}, 32'd1);
        check("retry instr", instrData, 32'h5555_6666);
        drive(0, 0, 0, 0, 0);
        step();
        check("retry pc", pc, 32'h404);

        // Reset in the middle of a REQ wait; late response must be ignored.
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step(); step();
        check("pre-reset mem_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        drive(0, 0, 0, 1, 32'hDEAD_BEEF);
        step();
        reset = 1'b0;
        irw_seen = 0;
        check("rst mem_req", {31'b0, mem_req}, 32'd0);
        check("rst pc", pc, 32'h0);
        check("rst instr", instrData, 32'h0);
        check("rst busy", {31'b0, fetch_busy}, 32'd0);
        check("rst fault", {31'b0, fetch_fault}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            if (IRWrite || mem_req) irw_seen++;
        end
        check("late data no activity", irw_seen, 32'd0);
        check("late data instr", instrData, 32'h0);
        check("late data pc", pc, 32'h0);

        // PC wrap, with fetch_start held through REQ/WRITE.
        drive(0, 1, 32'hFFFF_FFFC, 0, 0);
        step();
        check("wrap preload pc", pc, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0);
        step();
        check("wrap addr", mem_addr, 32'hFFFF_FFFC);
        irw_seen = 0;
        drive(1, 0, 0, 0, 0);
        step();
        check("wrap addr hold", mem_addr, 32'hFFFF_FFFC);
        drive(1, 0, 0, 1, 32'h0000_0077);
        step();
        if (IRWrite) irw_seen++;
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("wrap pc", pc, 32'h0);
        check("wrap idle mem_req", {31'b0, mem_req}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            if (IRWrite) irw_seen++;
            step();
        end
        check("wrap single IRWrite", irw_seen, 32'd1);
        check("wrap instr", instrData, 32'h0000_0077);
        check("wrap pc stable", pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
